// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers:
// default widths, exception codes, the entry record and the stage state encoding.
package pipe_pkg;

   localparam int          PC_W_DFLT     = 32;
   localparam int          DATA_W_DFLT   = 128;
   localparam int          EXC_W_DFLT    = 5;
   localparam logic [31:0] RESET_PC_DFLT = 32'h0000_3000;

   localparam logic [EXC_W_DFLT-1:0] EXC_NONE = 5'd0;
   localparam logic [EXC_W_DFLT-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W_DFLT-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W_DFLT-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_W_DFLT-1:0] EXC_OV   = 5'd12;
   localparam logic [EXC_W_DFLT-1:0] EXC_INT  = 5'd0;

   typedef struct packed {
      logic [PC_W_DFLT-1:0]   pc;
      logic [DATA_W_DFLT-1:0] data;
      logic [EXC_W_DFLT-1:0]  exc;
   } stage_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+entry register of a pipeline stage. Priority: reset > clear > load > drop.
// clear makes a bubble that zeroes payload and exception but captures d_pc for EPC.
module pipe_entry_reg #(
   parameter int              DATA_W = 128,
   parameter int              PC_W   = 32,
   parameter int              EXC_W  = 5,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              drop,
   input  logic              clear,
   input  logic [PC_W-1:0]   d_pc,
   input  logic [DATA_W-1:0] d_data,
   input  logic [EXC_W-1:0]  d_exc,
   output logic              valid,
   output logic [PC_W-1:0]   q_pc,
   output logic [DATA_W-1:0] q_data,
   output logic [EXC_W-1:0]  q_exc
);

   // drop only lowers valid so a popped head keeps showing its last fields
   always_ff @(posedge clk) begin
      if (reset) begin
         valid  <= 1'b0;
         q_pc   <= RST_PC;
         q_data <= '0;
         q_exc  <= '0;
      end else if (clear) begin
         valid  <= 1'b0;
         q_pc   <= d_pc;
         q_data <= '0;
         q_exc  <= '0;
      end else if (load) begin
         valid  <= 1'b1;
         q_pc   <= d_pc;
         q_data <= d_data;
         q_exc  <= d_exc;
      end else if (drop) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage carrying payload, PC and exception code, with an
// optional second (skid) entry so that in_ready comes straight from a flop.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int              DATA_W   = DATA_W_DFLT,
   parameter int              PC_W     = PC_W_DFLT,
   parameter int              EXC_W    = EXC_W_DFLT,
   parameter int              SKID     = 1,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DFLT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              int_flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [EXC_W-1:0]  in_exc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [EXC_W-1:0]  out_exc,
   output logic              int_hit,
   output logic [1:0]        occupancy
);

   stage_state_t      state, state_nxt;
   logic              acc, pop, kill;
   logic              main_valid, main_load, main_drop, main_from_skid;
   logic              skid_valid, skid_load, skid_drop;
   logic [PC_W-1:0]   skid_pc,   main_d_pc;
   logic [DATA_W-1:0] skid_data, main_d_data;
   logic [EXC_W-1:0]  skid_exc,  main_d_exc;

   assign kill     = flush | int_flush;
   assign in_ready = (SKID != 0) ? !skid_valid : (!main_valid | out_ready);
   assign acc      = in_valid & in_ready;
   assign pop      = main_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // A kill overrides every handshake; the entry registers do the zeroing themselves
   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_drop      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_drop      = 1'b0;
      if (kill) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  main_load = 1'b1;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc && pop) begin
                  main_load = 1'b1;
               end else if (acc) begin
                  skid_load = 1'b1;
                  state_nxt = ST_FULL;
               end else if (pop) begin
                  main_drop = 1'b1;
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_drop      = 1'b1;
                  state_nxt      = ST_ONE;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;
   assign main_d_data = main_from_skid ? skid_data : in_data;
   assign main_d_exc  = main_from_skid ? skid_exc  : in_exc;

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .PC_W   (PC_W),
      .EXC_W  (EXC_W),
      .RST_PC (RESET_PC)
   ) u_main (
      .clk    (clk),
      .reset  (reset),
      .load   (main_load),
      .drop   (main_drop),
      .clear  (kill),
      .d_pc   (main_d_pc),
      .d_data (main_d_data),
      .d_exc  (main_d_exc),
      .valid  (main_valid),
      .q_pc   (out_pc),
      .q_data (out_data),
      .q_exc  (out_exc)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_entry_reg #(
            .DATA_W (DATA_W),
            .PC_W   (PC_W),
            .EXC_W  (EXC_W),
            .RST_PC ('0)
         ) u_skid (
            .clk    (clk),
            .reset  (reset),
            .load   (skid_load),
            .drop   (skid_drop),
            .clear  (kill),
            .d_pc   (in_pc),
            .d_data (in_data),
            .d_exc  (in_exc),
            .valid  (skid_valid),
            .q_pc   (skid_pc),
            .q_data (skid_data),
            .q_exc  (skid_exc)
         );
      end else begin : g_noskid
         logic unused_skid_ctrl;
         assign unused_skid_ctrl = skid_load ^ skid_drop;
         assign skid_valid = 1'b0;
         assign skid_pc    = '0;
         assign skid_data  = '0;
         assign skid_exc   = '0;
      end
   endgenerate

   // Remembers whether the most recent kill came from an interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         int_hit <= 1'b0;
      end else if (kill) begin
         int_hit <= int_flush;
      end else if (acc) begin
         int_hit <= 1'b0;
      end
   end

   assign out_valid = main_valid;
   assign occupancy = {state == ST_FULL, state == ST_ONE};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: table of vectors on the SKID=1 instance,
// plus a hand-written stall sequence on the SKID=0 instance.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   logic         clk = 1'b0;
   logic         reset, flush, int_flush, in_valid, out_ready;
   logic [31:0]  in_pc;
   logic [127:0] in_data;
   logic [4:0]   in_exc;

   logic         s_in_ready, s_out_valid, s_int_hit;
   logic [31:0]  s_out_pc;
   logic [127:0] s_out_data;
   logic [4:0]   s_out_exc;
   logic [1:0]   s_occ;

   logic         p_in_ready, p_out_valid, p_int_hit;
   logic [31:0]  p_out_pc;
   logic [127:0] p_out_data;
   logic [4:0]   p_out_exc;
   logic [1:0]   p_occ;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.SKID(1)) dut_s (
      .clk(clk), .reset(reset), .flush(flush), .int_flush(int_flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
      .in_data(in_data), .in_exc(in_exc), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_pc(s_out_pc), .out_data(s_out_data),
      .out_exc(s_out_exc), .int_hit(s_int_hit), .occupancy(s_occ)
   );

   pipe_stage_skid #(.SKID(0)) dut_p (
      .clk(clk), .reset(reset), .flush(flush), .int_flush(int_flush),
      .in_valid(in_valid), .in_ready(p_in_ready), .in_pc(in_pc),
      .in_data(in_data), .in_exc(in_exc), .out_valid(p_out_valid),
      .out_ready(out_ready), .out_pc(p_out_pc), .out_data(p_out_data),
      .out_exc(p_out_exc), .int_hit(p_int_hit), .occupancy(p_occ)
   );

   typedef struct {
      logic         rst, fl, ifl, iv, ordy;
      stage_entry_t din;
      logic         ov, ih, ird;
      logic [1:0]   occ;
      stage_entry_t dexp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [127:0] mkData(input logic [31:0] pc);
      return {pc, ~pc, pc ^ 32'h1234_5678, 32'hCAFE_0000};
   endfunction

   function automatic vec_t mkv(input logic rst, fl, ifl, iv,
                                input logic [31:0] pc, input logic [4:0] exc,
                                input logic ordy, input logic ov,
                                input logic [31:0] opc, input logic [127:0] od,
                                input logic [4:0] oe, input logic ih,
                                input logic [1:0] occ, input logic ird);
      vec_t v;
      v.rst = rst; v.fl = fl; v.ifl = ifl; v.iv = iv; v.ordy = ordy;
      v.din.pc = pc; v.din.data = mkData(pc); v.din.exc = exc;
      v.ov = ov; v.ih = ih; v.ird = ird; v.occ = occ;
      v.dexp.pc = opc; v.dexp.data = od; v.dexp.exc = oe;
      return v;
   endfunction

   task automatic setIn(input logic rst, fl, ifl, iv, input logic [31:0] pc,
                        input logic [4:0] exc, input logic ordy);
      reset = rst; flush = fl; int_flush = ifl; in_valid = iv;
      in_pc = pc; in_data = mkData(pc); in_exc = exc; out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      setIn(v.rst, v.fl, v.ifl, v.iv, v.din.pc, v.din.exc, v.ordy);
      tick();
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      setIn(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 5'd0, 1'b0);

      //               rst fl ifl iv  in_pc        exc  ordy | ov  out_pc       out_data              exc  ih occ ird
      vecs.push_back(mkv(1, 0, 0, 0, 32'h3000, 0,        0,   0, 32'h3000, '0,                   0,   0, 0, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3000, 0,        1,   1, 32'h3000, mkData(32'h3000),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3004, 0,        1,   1, 32'h3004, mkData(32'h3004),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3008, 0,        1,   1, 32'h3008, mkData(32'h3008),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h300C, 0,        1,   1, 32'h300C, mkData(32'h300C),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3010, 0,        1,   1, 32'h3010, mkData(32'h3010),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 0, 32'h3014, 0,        1,   0, 32'h3010, mkData(32'h3010),     0,   0, 0, 1));
      // stall with continuous in_valid, then release
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3000, 0,        0,   1, 32'h3000, mkData(32'h3000),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3004, 0,        0,   1, 32'h3000, mkData(32'h3000),     0,   0, 2, 0));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3008, 0,        0,   1, 32'h3000, mkData(32'h3000),     0,   0, 2, 0));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3008, 0,        1,   1, 32'h3004, mkData(32'h3004),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3008, 0,        1,   1, 32'h3008, mkData(32'h3008),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 0, 32'h300C, 0,        1,   0, 32'h3008, mkData(32'h3008),     0,   0, 0, 1));
      // fill to FULL, then flush keeps the bubble PC
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3020, 0,        0,   1, 32'h3020, mkData(32'h3020),     0,   0, 1, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3024, EXC_ADEL, 0,   1, 32'h3020, mkData(32'h3020),     0,   0, 2, 0));
      vecs.push_back(mkv(0, 1, 0, 1, 32'h3040, 0,        0,   0, 32'h3040, '0,                   0,   0, 0, 1));
      // interrupt flush drops the accepted beat; next real accept clears int_hit
      vecs.push_back(mkv(0, 0, 1, 1, 32'h3050, EXC_OV,   0,   0, 32'h3050, '0,                   0,   1, 0, 1));
      vecs.push_back(mkv(0, 0, 0, 0, 32'h3054, 0,        0,   0, 32'h3050, '0,                   0,   1, 0, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3060, EXC_OV,   0,   1, 32'h3060, mkData(32'h3060),     12,  0, 1, 1));
      // flush and int_flush together behave as int_flush
      vecs.push_back(mkv(0, 1, 1, 0, 32'h3070, 0,        0,   0, 32'h3070, '0,                   0,   1, 0, 1));
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3080, EXC_ADES, 0,   1, 32'h3080, mkData(32'h3080),     5,   0, 1, 1));
      // reset beats flush while FULL
      vecs.push_back(mkv(0, 0, 0, 1, 32'h3084, 0,        0,   1, 32'h3080, mkData(32'h3080),     5,   0, 2, 0));
      vecs.push_back(mkv(1, 1, 0, 1, 32'h3090, 0,        0,   0, 32'h3000, '0,                   0,   0, 0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d out_valid", i), s_out_valid, vecs[i].ov);
         checkOutput($sformatf("v%0d out_pc", i),    s_out_pc,    vecs[i].dexp.pc);
         checkOutput($sformatf("v%0d out_data", i),  s_out_data,  vecs[i].dexp.data);
         checkOutput($sformatf("v%0d out_exc", i),   s_out_exc,   vecs[i].dexp.exc);
         checkOutput($sformatf("v%0d int_hit", i),   s_int_hit,   vecs[i].ih);
         checkOutput($sformatf("v%0d occupancy", i), s_occ,       vecs[i].occ);
         checkOutput($sformatf("v%0d in_ready", i),  s_in_ready,  vecs[i].ird);
      end

      // SKID=0: in_ready follows out_ready combinationally, never two entries
      setIn(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 5'd0, 1'b0);
      tick();
      checkOutput("p reset out_valid", p_out_valid, 1'b0);
      checkOutput("p reset out_pc",    p_out_pc,    32'h3000);
      checkOutput("p reset in_ready",  p_in_ready,  1'b1);

      setIn(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 5'd0, 1'b0);
      #1;
      checkOutput("p empty in_ready", p_in_ready, 1'b1);
      tick();
      checkOutput("p first out_valid", p_out_valid, 1'b1);
      checkOutput("p first out_pc",    p_out_pc,    32'h3000);
      checkOutput("p first occupancy", p_occ,       2'd1);
      checkOutput("p stall in_ready",  p_in_ready,  1'b0);

      for (int k = 0; k < 2; k++) begin
         setIn(1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 5'd0, 1'b0);
         tick();
         checkOutput($sformatf("p stall%0d occupancy", k), p_occ,      2'd1);
         checkOutput($sformatf("p stall%0d out_pc", k),    p_out_pc,   32'h3000);
         checkOutput($sformatf("p stall%0d in_ready", k),  p_in_ready, 1'b0);
      end

      setIn(1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 5'd0, 1'b1);
      #1;
      checkOutput("p release in_ready", p_in_ready, 1'b1);
      tick();
      checkOutput("p second out_valid", p_out_valid, 1'b1);
      checkOutput("p second out_pc",    p_out_pc,    32'h3004);
      checkOutput("p second out_data",  p_out_data,  mkData(32'h3004));
      checkOutput("p second occupancy", p_occ,       2'd1);

      setIn(1'b0, 1'b0, 1'b0, 1'b0, 32'h3008, 5'd0, 1'b1);
      tick();
      checkOutput("p drain out_valid", p_out_valid, 1'b0);
      checkOutput("p drain occupancy", p_occ,       2'd0);
      checkOutput("p drain out_pc",    p_out_pc,    32'h3004);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
